multdiv_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the execute stage of the 5-stage pipelined processor. It accepts a signed 32-bit mult or div from the execute stage and runs an iterative shift-add multiply or restoring divide over 32 cycles. While the operation runs, it holds a stall to the pipeline, then returns the result, destination register and exception flag for one cycle. It is the only owner of the iterative arithmetic registers.

---
 rtl/multdiv_sequencer_if.sv | 25 ++
 rtl/multdiv_sequencer.sv | 120 ++++++++++++
 tb/tb_multdiv_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the execute stage and the multiply/divide sequencer.
// The execute stage is the master; the sequencer is the slave.
interface multdiv_sequencer_if;
    logic        ex_start;
    logic        ex_op;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_rd;
    logic        kill;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  result_rd;
    logic        exception;

    modport master (
        output ex_start, ex_op, ex_a, ex_b, ex_rd, kill,
        input  stall, result_valid, result, result_rd, exception
    );

    modport slave (
        input  ex_start, ex_op, ex_a, ex_b, ex_rd, kill,
        output stall, result_valid, result, result_rd, exception
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring) sequencer.
// Operates on magnitudes for 32 cycles and then applies the sign on the way into DONE.
module multdiv_sequencer (
    input  logic               clock,
    input  logic               reset,
    multdiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [4:0]  count;
    logic        sign;
    logic [4:0]  rd_hold;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] prod_signed;
    logic [31:0] mul_res;
    logic        mul_exc;
    logic [32:0] div_shift;
    logic [32:0] div_sub;
    logic        div_fits;
    logic [31:0] quo_final;
    logic [31:0] div_res;
    logic        div_exc;

    // mag_a is the multiplier (shifted right) for mult, and dividend/quotient
    // (shifted left) for div; acc[32:0] holds the partial remainder during div.
    always_comb begin
        abs_a       = bus.ex_a[31] ? (32'd0 - bus.ex_a) : bus.ex_a;
        abs_b       = bus.ex_b[31] ? (32'd0 - bus.ex_b) : bus.ex_b;

        mul_sum     = {1'b0, acc[63:32]} + {1'b0, (mag_a[0] ? mag_b : 32'd0)};
        mul_next    = {mul_sum, acc[31:1]};
        prod_signed = sign ? (64'd0 - mul_next) : mul_next;
        mul_res     = prod_signed[31:0];
        mul_exc     = (prod_signed[63:32] != {32{prod_signed[31]}});

        div_shift   = {acc[31:0], mag_a[31]};
        div_sub     = div_shift - {1'b0, mag_b};
        div_fits    = (div_shift >= {1'b0, mag_b});
        quo_final   = {mag_a[30:0], div_fits};
        div_res     = sign ? (32'd0 - quo_final) : quo_final;
        div_exc     = ~sign & quo_final[31];
    end

    assign bus.stall = reset & ~bus.kill &
                       (((state == IDLE) & bus.ex_start) | (state == MUL) | (state == DIV));
    assign bus.result_valid = reset & ~bus.kill & (state == DONE);

    // Result registers are loaded only on the edge into DONE, so they hold until the next DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= 5'd0;
            sign          <= 1'b0;
            rd_hold       <= 5'd0;
            mag_a         <= 32'd0;
            mag_b         <= 32'd0;
            acc           <= 64'd0;
            bus.result    <= 32'd0;
            bus.result_rd <= 5'd0;
            bus.exception <= 1'b0;
        end else if (bus.kill) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ex_start) begin
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        sign    <= bus.ex_a[31] ^ bus.ex_b[31];
                        rd_hold <= bus.ex_rd;
                        count   <= 5'd0;
                        acc     <= 64'd0;
                        if (!bus.ex_op) begin
                            state <= MUL;
                        end else if (bus.ex_b == 32'd0) begin
                            state         <= DONE;
                            bus.result    <= 32'd0;
                            bus.result_rd <= bus.ex_rd;
                            bus.exception <= 1'b1;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    mag_a <= {1'b0, mag_a[31:1]};
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state         <= DONE;
                        bus.result    <= mul_res;
                        bus.result_rd <= rd_hold;
                        bus.exception <= mul_exc;
                    end
                end
                DIV: begin
                    acc   <= {31'd0, (div_fits ? div_sub : div_shift)};
                    mag_a <= quo_final;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state         <= DONE;
                        bus.result    <= div_res;
                        bus.result_rd <= rd_hold;
                        bus.exception <= div_exc;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed and random ops against a plain
// arithmetic reference model, plus kill, reset and back-to-back timing scenarios.
module tb_multdiv_sequencer;
    logic clock = 1'b0;
    logic reset;
    int   n_compared = 0;
    int   n_failed   = 0;

    multdiv_sequencer_if bus ();

    multdiv_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } vec_t;

    // Reference: signed product / truncating quotient straight from integer arithmetic.
    function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc);
        longint prod;
        if (!op) begin
            prod = longint'($signed(a)) * longint'($signed(b));
            res  = prod[31:0];
            exc  = (prod != longint'($signed(prod[31:0])));
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            res = 32'($signed(a) / $signed(b));
            exc = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 200)) - 32'd100;
            default: return 32'($urandom);
        endcase
    endfunction

    // Issues one op at posedge+1 and watches until result_valid; returns one cycle after DONE.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int stalls, output int latency,
                         output logic [31:0] res, output logic [4:0] rd_o, output logic exc);
        stalls  = 0;
        latency = -1;
        res     = 32'd0;
        rd_o    = 5'd0;
        exc     = 1'b0;
        bus.ex_start = 1'b1;
        bus.ex_op    = op;
        bus.ex_a     = a;
        bus.ex_b     = b;
        bus.ex_rd    = rd;
        for (int c = 0; c < 40 && latency < 0; c++) begin
            #1;
            if (bus.stall) stalls++;
            if (bus.result_valid) begin
                latency = c;
                res     = bus.result;
                rd_o    = bus.result_rd;
                exc     = bus.exception;
            end
            @(posedge clock);
            #1;
            bus.ex_start = 1'b0;
            bus.ex_a     = $urandom;
            bus.ex_b     = $urandom;
            bus.ex_rd    = 5'($urandom);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.ex_start = 1'b1;
        bus.ex_op    = 1'b0;
        bus.ex_a     = 32'd3;
        bus.ex_b     = 32'd4;
        bus.ex_rd    = 5'd1;
        bus.kill     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_compared++;
        if (bus.stall !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
        n_compared++;
        if (bus.result_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.result_valid); end
        n_compared++;
        if (bus.result !== 32'd0) begin n_failed++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result); end
        n_compared++;
        if (bus.result_rd !== 5'd0) begin n_failed++; $display("[TB] FAIL reset_rd: got %h expected 0", bus.result_rd); end
        n_compared++;
        if (bus.exception !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_exc: got %b expected 0", bus.exception); end
        reset        = 1'b1;
        bus.ex_start = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_arith();
        vec_t        vecs[$];
        int          st, lat, exp_lat;
        logic [31:0] r, er;
        logic [4:0]  rr;
        logic        e, ee;
        vecs.push_back('{1'b0, 32'd6,          32'd7,          5'd5});
        vecs.push_back('{1'b0, -32'sd7,        32'd6,          5'd6});
        vecs.push_back('{1'b1, 32'd100,        -32'sd7,        5'd7});
        vecs.push_back('{1'b1, -32'sd100,      -32'sd7,        5'd8});
        vecs.push_back('{1'b0, 32'h0001_0000,  32'h0001_0000,  5'd9});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10});
        vecs.push_back('{1'b1, 32'd5,          32'd0,          5'd11});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'd1,          5'd12});
        for (int i = 0; i < 24; i++)
            vecs.push_back('{1'($urandom), rand_operand(), rand_operand(), 5'($urandom)});
        foreach (vecs[i]) begin
            model(vecs[i].op, vecs[i].a, vecs[i].b, er, ee);
            exp_lat = (vecs[i].op && vecs[i].b == 32'd0) ? 1 : 33;
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, st, lat, r, rr, e);
            n_compared++;
            if (lat !== exp_lat) begin n_failed++; $display("[TB] FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
            n_compared++;
            if (st !== exp_lat) begin n_failed++; $display("[TB] FAIL arith_stalls[%0d]: got %0d expected %0d", i, st, exp_lat); end
            n_compared++;
            if (r !== er) begin n_failed++; $display("[TB] FAIL arith_result[%0d] op=%b a=%h b=%h: got %h expected %h", i, vecs[i].op, vecs[i].a, vecs[i].b, r, er); end
            n_compared++;
            if (rr !== vecs[i].rd) begin n_failed++; $display("[TB] FAIL arith_rd[%0d]: got %h expected %h", i, rr, vecs[i].rd); end
            n_compared++;
            if (e !== ee) begin n_failed++; $display("[TB] FAIL arith_exc[%0d] op=%b a=%h b=%h: got %b expected %b", i, vecs[i].op, vecs[i].a, vecs[i].b, e, ee); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] er;
        logic        ee;
        model(1'b0, -32'sd123, 32'd456, er, ee);
        bus.ex_start = 1'b1;
        bus.ex_op    = 1'b0;
        bus.ex_a     = -32'sd123;
        bus.ex_b     = 32'd456;
        bus.ex_rd    = 5'd17;
        repeat (33) begin @(posedge clock); #1; end
        #1;
        n_compared++;
        if (bus.result_valid !== 1'b1) begin n_failed++; $display("[TB] FAIL b2b_first_valid: got %b expected 1", bus.result_valid); end
        n_compared++;
        if (bus.stall !== 1'b0) begin n_failed++; $display("[TB] FAIL b2b_done_stall: got %b expected 0", bus.stall); end
        n_compared++;
        if (bus.result !== er) begin n_failed++; $display("[TB] FAIL b2b_first_result: got %h expected %h", bus.result, er); end
        @(posedge clock);
        #2;
        n_compared++;
        if (bus.stall !== 1'b1) begin n_failed++; $display("[TB] FAIL b2b_reaccept_stall: got %b expected 1", bus.stall); end
        @(posedge clock);
        #1;
        bus.ex_start = 1'b0;
        repeat (32) begin @(posedge clock); #1; end
        #1;
        n_compared++;
        if (bus.result_valid !== 1'b1) begin n_failed++; $display("[TB] FAIL b2b_second_valid: got %b expected 1", bus.result_valid); end
        n_compared++;
        if (bus.result_rd !== 5'd17) begin n_failed++; $display("[TB] FAIL b2b_second_rd: got %h expected 11", bus.result_rd); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_kill();
        int          st, lat, valid_seen;
        logic [31:0] r, er;
        logic [4:0]  rr;
        logic        e, ee;
        valid_seen   = 0;
        bus.ex_start = 1'b1;
        bus.ex_op    = 1'b0;
        bus.ex_a     = 32'd1234;
        bus.ex_b     = -32'sd77;
        bus.ex_rd    = 5'd3;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.result_valid) valid_seen++;
            @(posedge clock);
            #1;
            bus.ex_start = 1'b0;
        end
        bus.kill = 1'b1;
        #1;
        n_compared++;
        if (bus.stall !== 1'b0) begin n_failed++; $display("[TB] FAIL kill_stall: got %b expected 0", bus.stall); end
        if (bus.result_valid) valid_seen++;
        @(posedge clock);
        #1;
        bus.kill = 1'b0;
        model(1'b1, 32'd1000, -32'sd33, er, ee);
        do_op(1'b1, 32'd1000, -32'sd33, 5'd9, st, lat, r, rr, e);
        n_compared++;
        if (valid_seen !== 0) begin n_failed++; $display("[TB] FAIL kill_no_valid: got %0d pulses expected 0", valid_seen); end
        n_compared++;
        if (lat !== 33) begin n_failed++; $display("[TB] FAIL kill_restart_latency: got %0d expected 33", lat); end
        n_compared++;
        if (r !== er) begin n_failed++; $display("[TB] FAIL kill_restart_result: got %h expected %h", r, er); end

        bus.ex_start = 1'b1;
        bus.ex_op    = 1'b1;
        bus.ex_a     = 32'd50;
        bus.ex_b     = 32'd0;
        @(posedge clock);
        #1;
        bus.ex_start = 1'b0;
        bus.kill     = 1'b1;
        #1;
        n_compared++;
        if (bus.result_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL kill_in_done_valid: got %b expected 0", bus.result_valid); end
        @(posedge clock);
        #1;
        bus.ex_start = 1'b1;
        #1;
        n_compared++;
        if (bus.stall !== 1'b0) begin n_failed++; $display("[TB] FAIL kill_in_idle_stall: got %b expected 0", bus.stall); end
        bus.ex_start = 1'b0;
        bus.kill     = 1'b0;
        @(posedge clock);
        #1;
        #1;
        n_compared++;
        if (bus.result_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL kill_after_done_valid: got %b expected 0", bus.result_valid); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int          st, lat, valid_seen;
        logic [31:0] r, er;
        logic [4:0]  rr;
        logic        e, ee;
        do_op(1'b0, 32'd9, 32'd3, 5'd4, st, lat, r, rr, e);
        n_compared++;
        if (r !== 32'd27) begin n_failed++; $display("[TB] FAIL pre_reset_result: got %h expected 1b", r); end
        bus.ex_start = 1'b1;
        bus.ex_op    = 1'b1;
        bus.ex_a     = -32'sd1000;
        bus.ex_b     = 32'd7;
        bus.ex_rd    = 5'd12;
        repeat (20) begin @(posedge clock); #1; bus.ex_start = 1'b0; end
        reset = 1'b0;
        #1;
        n_compared++;
        if (bus.stall !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_mid_stall_during: got %b expected 0", bus.stall); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_compared++;
        if (bus.stall !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_mid_stall_after: got %b expected 0", bus.stall); end
        n_compared++;
        if (bus.result !== 32'd0) begin n_failed++; $display("[TB] FAIL reset_mid_result: got %h expected 0", bus.result); end
        n_compared++;
        if (bus.result_rd !== 5'd0) begin n_failed++; $display("[TB] FAIL reset_mid_rd: got %h expected 0", bus.result_rd); end
        valid_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.result_valid) valid_seen++;
            @(posedge clock);
            #2;
        end
        n_compared++;
        if (valid_seen !== 0) begin n_failed++; $display("[TB] FAIL reset_mid_no_valid: got %0d pulses expected 0", valid_seen); end
        @(posedge clock);
        #1;
        model(1'b1, -32'sd1000, 32'd7, er, ee);
        do_op(1'b1, -32'sd1000, 32'd7, 5'd12, st, lat, r, rr, e);
        n_compared++;
        if (lat !== 33) begin n_failed++; $display("[TB] FAIL reset_mid_latency: got %0d expected 33", lat); end
        n_compared++;
        if (r !== er) begin n_failed++; $display("[TB] FAIL reset_mid_new_result: got %h expected %h", r, er); end
        n_compared++;
        if (e !== ee) begin n_failed++; $display("[TB] FAIL reset_mid_new_exc: got %b expected %b", e, ee); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        bus.ex_start = 1'b0;
        bus.ex_op    = 1'b0;
        bus.ex_a     = 32'd0;
        bus.ex_b     = 32'd0;
        bus.ex_rd    = 5'd0;
        bus.kill     = 1'b0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_kill();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
